// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative AES InvMixColumns, one shared column mixer over four cycles, with bypass.
module mix_column_helper (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  logic [7:0] a [4];
  logic [7:0] m9 [4], mb [4], md [4], me [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i] = col_in[31-8*i -: 8];
      m9[i] = xt(xt(xt(a[i]))) ^ a[i];
      mb[i] = m9[i] ^ xt(a[i]);
      md[i] = m9[i] ^ xt(xt(a[i]));
      me[i] = xt(xt(xt(a[i]))) ^ xt(xt(a[i])) ^ xt(a[i]);
    end
    col_out = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  end
endmodule

module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         bypass,
  input  logic [127:0] state_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t state, state_next;
  logic [1:0] col;
  logic [127:0] work;
  logic [31:0] mixed;
  mix_column_helper u_mix (.col_in(work[{~col, 5'b0} +: 32]), .col_out(mixed));
  always_comb begin
    state_next = (state == RUN) ? ((col == 2'd3) ? DONE : RUN)
               : start ? (bypass ? DONE : RUN) : IDLE;
    ready = (state != RUN);
    busy = (state == RUN);
    done = (state == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= 2'd0;
      work <= '0;
      state_out <= '0;
    end else begin
      state <= state_next;
      if (state == RUN) begin
        work[{~col, 5'b0} +: 32] <= mixed;
        col <= col + 2'd1;
        if (col == 2'd3) state_out <= {work[127:32], mixed};
      end else if (start) begin
        if (bypass) state_out <= state_in;
        else begin
          work <= state_in;
          col <= 2'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: directed and random checks against a GF(2^8) matrix reference model.
module tb_inv_mix_columns_seq;
  logic clk = 0, rst = 1, start = 0, bypass = 0;
  logic [127:0] state_in = '0;
  logic ready, busy, done;
  logic [127:0] state_out;
  int tests = 0, fails = 0;
  logic [127:0] last_exp = '0;

  inv_mix_columns_seq dut (.clk(clk), .rst(rst), .start(start), .bypass(bypass),
    .state_in(state_in), .ready(ready), .busy(busy), .done(done), .state_out(state_out));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] in_b [4];
    logic [7:0] acc;
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) in_b[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - row + 4) % 4], in_b[k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Called at a negedge; leaves the bench at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [127:0] data, input logic byp);
    int lat = 0, busy_n = 0;
    logic held = 1;
    logic [127:0] exp = byp ? data : ref_mix(data);
    state_in = data; bypass = byp; start = 1;
    do begin
      @(negedge clk);
      start = 0;
      lat++;
      busy_n += busy;
      if (!done && state_out !== last_exp) held = 0;
    end while (!done && lat < 20);
    check({tag, " latency"}, 128'(lat), byp ? 128'd1 : 128'd5);
    check({tag, " busy cycles"}, 128'(busy_n), byp ? 128'd0 : 128'd4);
    check({tag, " result"}, state_out, exp);
    check({tag, " prior held"}, 128'(held), 128'd1);
    last_exp = exp;
  endtask

  initial begin
    logic [127:0] kv = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    int dn;
    rst = 1; start = 1;
    repeat (2) @(negedge clk);
    check("reset state_out", state_out, 0);
    check("reset outputs", 128'({ready, busy, done}), 128'b100);
    rst = 0; start = 0;
    @(negedge clk);
    check("post reset idle", 128'({ready, busy, done}), 128'b100);

    run_op("known", kv, 0);
    check("known vector", state_out, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    run_op("b2b", 128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_01010101, 0);
    check("b2b vector", state_out, 128'h2d26314c_d4d4d4d5_c6c6c6c6_01010101);
    @(negedge clk);
    check("done pulse ends", 128'(done), 0);

    run_op("bypass", 128'h00112233_44556677_8899aabb_ccddeeff, 1);
    run_op("bypass b2b", 128'hffeeddcc_bbaa9988_77665544_33221100, 1);
    @(negedge clk);

    // start during RUN must be ignored
    state_in = kv; bypass = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); state_in = ~kv; bypass = 1; start = 1;
    @(negedge clk); start = 0;
    dn = 0;
    repeat (8) begin @(negedge clk); dn += done; end
    check("ignored start result", state_out, ref_mix(kv));
    check("ignored start dones", 128'(dn), 1);
    last_exp = ref_mix(kv);

    // reset two cycles into RUN
    state_in = ~kv; bypass = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    check("midrun reset state_out", state_out, 0);
    check("midrun reset outputs", 128'({ready, busy, done}), 128'b100);
    dn = 0;
    repeat (6) begin @(negedge clk); dn += done; end
    check("midrun no done", 128'(dn), 0);
    last_exp = 0;
    run_op("after reset", kv ^ 128'h5a, 0);

    for (int i = 0; i < 25; i++) begin
      logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
      run_op("rand", d, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Iterative InvMixColumns engine for the AES-256 decryption round pipeline. It accepts a 128-bit state, runs it through one shared 32-bit column inverse-mix unit (MixColumnHelper) over four consecutive cycles, and returns the transformed state with a one-cycle done pulse. A bypass request (the final decryption round, which has no InvMixColumns) returns the state unchanged with reduced latency. The round controller drives it between InvSubBytes/AddRoundKey and the next round.

## Interface
- No parameters.
- clk  input  1  Rising-edge clock.
- rst  input  1  Synchronous, active-high reset.
- start  input  1  Request; sampled only when ready=1.
- bypass  input  1  Sampled with start; 1 = pass state through without mixing.
- state_in  input  128  Input state. Column 0 = [127:96], column 3 = [31:0]; byte order within each column is MSB first.
- ready  output  1  1 in IDLE and DONE (a new start is accepted).
- busy  output  1  1 while columns are being processed.
- done  output  1  One-cycle pulse; state_out is valid from this cycle.
- state_out  output  128  Result register; held until the next done.

## Operation
- Exactly one MixColumnHelper instance. Its input is the work-register column selected by the 2-bit column counter `col`.
- FSM states:
  - IDLE: ready=1.
    - start=1 & bypass=0 → load work ← state_in, col ← 0, go to RUN.
    - start=1 & bypass=1 → state_out ← state_in, go to DONE.
  - RUN: busy=1.
    - Each cycle, work[col] ← mix(work[col]) and col ← col+1.
    - On the cycle that col=3: state_out ← work with column 3 replaced by its mixed value, col wraps to 0, go to DONE.
  - DONE: done=1, ready=1.
    - start accepted exactly as in IDLE (back-to-back operation).
    - Otherwise go to IDLE.
- start while busy=1 is ignored. It is not queued, and state_in/bypass changes during RUN have no effect.
- work register is 128 bits. Only the addressed 32-bit column is written per cycle; the other columns hold.
- mix() is the GF(2^8) inverse MixColumns matrix [0e 0b 0d 09; 09 0e 0b 0d; 0d 09 0e 0b; 0b 0d 09 0e], computed purely combinationally by the helper.

## Timing
- Reset (rst=1 at an edge): FSM ← IDLE, col ← 0, work ← 0, state_out ← 0, done=0, busy=0, ready=1. Reset mid-RUN aborts the operation; no done is produced.
- Mixing latency, with start sampled at edge E0:
  - busy=1 after E0 through E4.
  - Columns 0..3 are written at E1..E4.
  - done=1 and state_out valid after E4, for exactly one cycle.
  - Start-to-done is 5 cycles.
- Bypass latency: done=1 after E0 (1 cycle); state_out equals the sampled state_in.
- Back-to-back: a start during the DONE cycle is sampled at that cycle's edge.
  - Mixing throughput: one state per 5 cycles.
  - Bypass throughput: one state per cycle, with done held high continuously.
- state_out changes only at the edge that enters DONE (or at reset).
- The outputs ready, busy and done are decoded from FSM state only and never depend combinationally on start.

## Test plan
- Reset: hold rst for 2 cycles with start=1 → state_out=0, done=0, busy=0, ready=1; no operation starts.
- Known vector: state_in=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, bypass=0 → done exactly 5 cycles after start, with state_out=128'hdb135345_f20a225c_01010101_c6c6c6c6 and busy high for 4 cycles.
- Bypass: state_in=128'h00112233_44556677_8899aabb_ccddeeff, bypass=1 → done 1 cycle after start, with state_out equal to state_in and busy never asserted.
- Ignored start: issue the known vector, then pulse start with a different state_in during RUN → result unchanged and exactly one done pulse.
- Back-to-back: assert start in the DONE cycle with state_in=128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_01010101 → second done 5 cycles later with state_out=128'h2d26314c_d4d4d4d5_c6c6c6c6_01010101; the first result is held until that edge.
- Reset mid-operation: assert rst 2 cycles into RUN → next cycle IDLE with all outputs at reset values and no done; a subsequent start produces a correct result.
